// File: rtl/issue_scheduler.sv
// In-order LANES-wide issue scheduler with a 32-entry register scoreboard and intra-bundle RAW/WAW checks.
// Optional build macro SCHED_PERF_EN adds saturating performance counters (perf_issued, perf_hazard_stall, perf_dual).
module issue_scheduler #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*XLEN-1:0] in_instr,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  stall,
  input  logic                  flush,
  output logic [LANES-1:0]      iss_valid,
  output logic [LANES*XLEN-1:0] iss_instr,
  input  logic [LANES-1:0]      wb_valid,
  input  logic [LANES*5-1:0]    wb_rd,
  output logic [31:0]           pending_regs,
  output logic                  busy
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_hazard_stall,
  output logic [31:0]           perf_dual
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                  state_r;
  logic [LANES*XLEN-1:0]   hold_instr_r;
  logic [LANES-1:0]        hold_pend_r;
  logic [LANES-1:0]        iss_valid_r;
  logic [LANES*XLEN-1:0]   iss_instr_r;
  logic [31:0]             pending_regs_r;

  logic                    can_issue_s;
  logic [LANES-1:0]        issue_s;
  logic [LANES-1:0]        accept_pend_s;
  logic [31:0]             issue_rd_mask_s;
  logic [31:0]             sb_nx_s;

  function automatic logic [31:0] reg_bit(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

  function automatic logic uses_rd(input logic [31:0] ins);
    return (ins[6:0] != OPC_STORE) && (ins[6:0] != OPC_BRANCH);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ins);
    return (ins[6:0] != OPC_LUI) && (ins[6:0] != OPC_AUIPC) && (ins[6:0] != OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ins);
    return (ins[6:0] == OPC_OP) || (ins[6:0] == OPC_STORE) || (ins[6:0] == OPC_BRANCH);
  endfunction

  // Destination mask; x0 is dropped so it can never create a hazard.
  function automatic logic [31:0] rd_mask(input logic [31:0] ins);
    return (uses_rd(ins) ? reg_bit(ins[11:7]) : 32'd0) & 32'hFFFF_FFFE;
  endfunction

  function automatic logic [31:0] used_mask(input logic [31:0] ins);
    logic [31:0] m;
    m = rd_mask(ins);
    m = m | (uses_rs1(ins) ? reg_bit(ins[19:15]) : 32'd0);
    m = m | (uses_rs2(ins) ? reg_bit(ins[24:20]) : 32'd0);
    return m & 32'hFFFF_FFFE;
  endfunction

  function automatic logic [2:0] pop_count(input logic [LANES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  assign in_ready     = (state_r == ST_EMPTY) & ~flush;
  assign iss_valid    = iss_valid_r;
  assign iss_instr    = iss_instr_r;
  assign pending_regs = pending_regs_r;
  assign busy         = (state_r == ST_HOLD) | (|pending_regs_r);
  assign can_issue_s  = (state_r == ST_HOLD) & ~stall & ~flush;

  // Slots with a nonzero instruction and mask bit become pending on accept.
  always_comb begin
    accept_pend_s = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      accept_pend_s[k] = in_mask[k] & (in_instr[k*XLEN +: XLEN] != {XLEN{1'b0}});
    end
  end

  // In-order prefix selection: the first blocked pending slot stops every younger slot.
  always_comb begin
    logic        prefix_ok;
    logic [31:0] lower_rd;
    logic [31:0] ins;
    issue_s         = {LANES{1'b0}};
    issue_rd_mask_s = 32'd0;
    prefix_ok       = can_issue_s;
    lower_rd        = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      ins = hold_instr_r[k*XLEN +: 32];
      if (hold_pend_r[k]) begin
        if (prefix_ok && ((used_mask(ins) & (pending_regs_r | lower_rd)) == 32'd0)) begin
          issue_s[k]      = 1'b1;
          issue_rd_mask_s = issue_rd_mask_s | rd_mask(ins);
        end else begin
          prefix_ok = 1'b0;
        end
        lower_rd = lower_rd | rd_mask(ins);
      end else begin
        lower_rd = lower_rd;
      end
    end
  end

  // Scoreboard next value: writebacks clear first, then issue sets so set wins.
  always_comb begin
    sb_nx_s = pending_regs_r;
    for (int k = 0; k < LANES; k++) begin
      if (wb_valid[k]) begin
        sb_nx_s[wb_rd[k*5 +: 5]] = 1'b0;
      end else begin
        sb_nx_s = sb_nx_s;
      end
    end
    sb_nx_s = (sb_nx_s | issue_rd_mask_s) & 32'hFFFF_FFFE;
  end

  // Control FSM, hold registers, issue outputs and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_EMPTY;
      hold_instr_r   <= {(LANES*XLEN){1'b0}};
      hold_pend_r    <= {LANES{1'b0}};
      iss_valid_r    <= {LANES{1'b0}};
      iss_instr_r    <= {(LANES*XLEN){1'b0}};
      pending_regs_r <= 32'd0;
    end else begin
      pending_regs_r <= sb_nx_s;
      if (flush) begin
        state_r     <= ST_EMPTY;
        hold_pend_r <= {LANES{1'b0}};
        iss_valid_r <= {LANES{1'b0}};
      end else begin
        case (state_r)
          ST_EMPTY: begin
            iss_valid_r <= {LANES{1'b0}};
            if (in_valid) begin
              hold_instr_r <= in_instr;
              hold_pend_r  <= accept_pend_s;
              state_r      <= (|accept_pend_s) ? ST_HOLD : ST_EMPTY;
            end else begin
              state_r <= ST_EMPTY;
            end
          end
          ST_HOLD: begin
            if (stall) begin
              iss_valid_r <= {LANES{1'b0}};
            end else begin
              iss_valid_r <= issue_s;
              for (int k = 0; k < LANES; k++) begin
                if (issue_s[k]) begin
                  iss_instr_r[k*XLEN +: XLEN] <= hold_instr_r[k*XLEN +: XLEN];
                end
              end
              hold_pend_r <= hold_pend_r & ~issue_s;
              state_r     <= ((hold_pend_r & ~issue_s) == {LANES{1'b0}}) ? ST_EMPTY : ST_HOLD;
            end
          end
          default: begin
            state_r     <= ST_EMPTY;
            hold_pend_r <= {LANES{1'b0}};
            iss_valid_r <= {LANES{1'b0}};
          end
        endcase
      end
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] perf_issued_r;
  logic [31:0] perf_hazard_stall_r;
  logic [31:0] perf_dual_r;
  logic [2:0]  issue_cnt_s;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {30'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign issue_cnt_s       = pop_count(issue_s);
  assign perf_issued       = perf_issued_r;
  assign perf_hazard_stall = perf_hazard_stall_r;
  assign perf_dual         = perf_dual_r;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_r       <= 32'd0;
      perf_hazard_stall_r <= 32'd0;
      perf_dual_r         <= 32'd0;
    end else begin
      perf_issued_r <= sat_add(perf_issued_r, issue_cnt_s);
      if ((state_r == ST_HOLD) && !stall && (issue_cnt_s == 3'd0)) begin
        perf_hazard_stall_r <= sat_add(perf_hazard_stall_r, 3'd1);
      end else begin
        perf_hazard_stall_r <= perf_hazard_stall_r;
      end
      if (issue_cnt_s >= 3'd2) begin
        perf_dual_r <= sat_add(perf_dual_r, 3'd1);
      end else begin
        perf_dual_r <= perf_dual_r;
      end
    end
  end
`endif

endmodule
